// File: rtl/pulse_gen_multi.sv
// Multi-channel programmable pulse generator: delay, min-width pulse,
// optional wait-stretch and repeated pulses with a gap, per channel.
module pulse_gen_multi #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         start,
    input  logic [NUM_CH-1:0]         abort,
    input  logic [NUM_CH*CNT_W-1:0]   delay_cnt,
    input  logic [NUM_CH*CNT_W-1:0]   width_cnt,
    input  logic [NUM_CH*CNT_W-1:0]   gap_cnt,
    input  logic [NUM_CH*CNT_W-1:0]   repeat_cnt,
    input  logic [NUM_CH-1:0]         wait_en,
    input  logic [NUM_CH-1:0]         wait_on,
    output logic [NUM_CH-1:0]         pulse,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state;
        state_t           state_nx;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] dly_m1;
        logic [CNT_W-1:0] wid_m1;
        logic [CNT_W-1:0] gap_m1;
        logic [CNT_W-1:0] rem;
        logic             wen;
        logic             done_r;
        logic             done_nx;
        logic             load;
        logic             dec;
        logic [CNT_W-1:0] d_in;
        logic [CNT_W-1:0] w_in;
        logic [CNT_W-1:0] g_in;
        logic [CNT_W-1:0] r_in;

        assign d_in = delay_cnt[i*CNT_W +: CNT_W];
        assign w_in = width_cnt[i*CNT_W +: CNT_W];
        assign g_in = gap_cnt[i*CNT_W +: CNT_W];
        assign r_in = repeat_cnt[i*CNT_W +: CNT_W];

        always_comb begin
            state_nx = state;
            load     = 1'b0;
            done_nx  = 1'b0;
            dec      = 1'b0;
            unique case (state)
                IDLE: begin
                    if (start[i]) begin
                        load     = 1'b1;
                        state_nx = (d_in != '0) ? DELAY : PULSE;
                    end
                end
                DELAY: begin
                    if (cnt == dly_m1) state_nx = PULSE;
                end
                PULSE, HOLD: begin
                    // HOLD releases on wait_on; PULSE ends on its last width cycle
                    if ((state == PULSE && cnt == wid_m1) ||
                        (state == HOLD && wait_on[i])) begin
                        if (state == PULSE && wen && !wait_on[i]) begin
                            state_nx = HOLD;
                        end else if (rem != '0) begin
                            state_nx = GAP;
                        end else begin
                            state_nx = IDLE;
                            done_nx  = 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (cnt == gap_m1) begin
                        state_nx = PULSE;
                        dec      = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
            if (abort[i]) begin
                state_nx = IDLE;
                load     = 1'b0;
                done_nx  = 1'b0;
                dec      = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state  <= IDLE;
                cnt    <= '0;
                dly_m1 <= '0;
                wid_m1 <= '0;
                gap_m1 <= '0;
                rem    <= '0;
                wen    <= 1'b0;
                done_r <= 1'b0;
            end else begin
                state  <= state_nx;
                done_r <= done_nx;
                if (state_nx != state || state == IDLE) cnt <= '0;
                else                                    cnt <= cnt + ONE;
                if (load) begin
                    dly_m1 <= d_in - ONE;
                    wid_m1 <= (w_in == '0) ? '0 : w_in - ONE;
                    gap_m1 <= (g_in == '0) ? '0 : g_in - ONE;
                    rem    <= r_in;
                    wen    <= wait_en[i];
                end else if (dec) begin
                    rem <= rem - ONE;
                end
            end
        end

        assign pulse[i] = (state == PULSE) || (state == HOLD);
        assign busy[i]  = (state != IDLE);
        assign done[i]  = done_r;
    end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Self-checking bench for pulse_gen_multi: directed vector table,
// corner sequences, and random traffic against a schedule-queue model.
module tb_pulse_gen_multi;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   start, abort, wait_en, wait_on;
    logic [N*W-1:0] delay_cnt, width_cnt, gap_cnt, repeat_cnt;
    logic [N-1:0]   pulse, busy, done;

    int tests = 0;
    int fails = 0;

    pulse_gen_multi #(.NUM_CH(N), .CNT_W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .delay_cnt(delay_cnt), .width_cnt(width_cnt),
        .gap_cnt(gap_cnt), .repeat_cnt(repeat_cnt),
        .wait_en(wait_en), .wait_on(wait_on),
        .pulse(pulse), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          d, w, g, r;
        logic        we;
        int          wfrom;
        logic [31:0] pmask;
        int          dcyc;
    } vec_t;
    vec_t tbl[6];

    // Expected output schedule entry: pulse level and "last width cycle".
    typedef struct packed {
        logic p;
        logic last;
    } ent_t;
    ent_t mq[N][$];
    logic m_p[N], m_b[N], m_d[N], m_l[N], m_we[N];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input int d, input int w,
                          input int g, input int r, input logic we);
        delay_cnt[c*W +: W]  = W'(d);
        width_cnt[c*W +: W]  = W'(w);
        gap_cnt[c*W +: W]    = W'(g);
        repeat_cnt[c*W +: W] = W'(r);
        wait_en[c]           = we;
    endtask

    task automatic clear_in;
        start = '0; abort = '0; wait_en = '0; wait_on = '0;
        delay_cnt = '0; width_cnt = '0; gap_cnt = '0; repeat_cnt = '0;
    endtask

    task automatic do_reset;
        clear_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic model_step;
        for (int c = 0; c < N; c++) begin
            ent_t e;
            if (reset || abort[c]) begin
                mq[c].delete();
                m_b[c] = 0; m_p[c] = 0; m_d[c] = 0; m_l[c] = 0;
            end else begin
                m_d[c] = 0;
                if (m_b[c]) begin
                    if (!(m_l[c] && m_we[c] && !wait_on[c])) begin
                        if (mq[c].size() == 0) begin
                            m_b[c] = 0; m_p[c] = 0; m_l[c] = 0; m_d[c] = 1;
                        end else begin
                            e = mq[c].pop_front();
                            m_p[c] = e.p; m_l[c] = e.last;
                        end
                    end
                end else if (start[c]) begin
                    int d, w1, g1, r;
                    d  = int'(delay_cnt[c*W +: W]);
                    w1 = int'(width_cnt[c*W +: W]);
                    g1 = int'(gap_cnt[c*W +: W]);
                    r  = int'(repeat_cnt[c*W +: W]);
                    if (w1 == 0) w1 = 1;
                    if (g1 == 0) g1 = 1;
                    for (int j = 0; j < d; j++) mq[c].push_back('{1'b0, 1'b0});
                    for (int k = 0; k <= r; k++) begin
                        for (int j = 0; j < w1; j++)
                            mq[c].push_back('{1'b1, j == w1 - 1});
                        if (k < r)
                            for (int j = 0; j < g1; j++)
                                mq[c].push_back('{1'b0, 1'b0});
                    end
                    m_we[c] = wait_en[c];
                    e = mq[c].pop_front();
                    m_b[c] = 1; m_p[c] = e.p; m_l[c] = e.last;
                end
            end
        end
    endtask

    initial begin
        logic [N-1:0] ep, eb, ed;
        int           k, cntp;
        logic         seen;

        tbl[0] = '{0, 3, 0, 0, 1'b0, 0, 32'h0000_000E, 4};
        tbl[1] = '{2, 2, 1, 2, 1'b0, 0, 32'h0000_06D8, 11};
        tbl[2] = '{0, 2, 0, 0, 1'b1, 6, 32'h0000_007E, 7};
        tbl[3] = '{0, 2, 0, 0, 1'b1, 0, 32'h0000_0006, 3};
        tbl[4] = '{0, 0, 0, 1, 1'b0, 0, 32'h0000_000A, 4};
        tbl[5] = '{3, 1, 0, 0, 1'b0, 0, 32'h0000_0010, 5};

        clear_in();
        reset = 1'b1;
        tick();
        tick();
        chk("reset_state", {pulse, busy, done}, '0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_reset();
            set_ch(0, tbl[i].d, tbl[i].w, tbl[i].g, tbl[i].r, tbl[i].we);
            for (int cyc = 0; cyc < 24; cyc++) begin
                start[0]   = (cyc == 0);
                wait_on[0] = (cyc >= tbl[i].wfrom);
                tick();
                k = cyc + 1;
                chk($sformatf("tbl%0d_pulse_c%0d", i, k), pulse[0], tbl[i].pmask[k]);
                chk($sformatf("tbl%0d_done_c%0d", i, k), done[0], k == tbl[i].dcyc);
                chk($sformatf("tbl%0d_busy_c%0d", i, k), busy[0],
                    k >= 1 && k < tbl[i].dcyc);
            end
        end

        // abort mid-pulse, with an ignored start while busy
        do_reset();
        set_ch(0, 0, 10, 0, 0, 1'b0);
        for (int cyc = 0; cyc < 16; cyc++) begin
            start[0] = (cyc == 0 || cyc == 2);
            abort[0] = (cyc == 4);
            if (cyc == 2) set_ch(0, 5, 1, 0, 0, 1'b0);
            tick();
            k = cyc + 1;
            chk($sformatf("abort_pulse_c%0d", k), pulse[0], k >= 1 && k <= 4);
            chk($sformatf("abort_done_c%0d", k), done[0], 1'b0);
        end

        // reset mid-pulse
        do_reset();
        set_ch(0, 0, 10, 0, 0, 1'b0);
        for (int cyc = 0; cyc < 8; cyc++) begin
            start[0] = (cyc == 0);
            reset    = (cyc == 4);
            tick();
            k = cyc + 1;
            chk($sformatf("rst_pulse_c%0d", k), pulse[0], k >= 1 && k <= 4);
            if (k >= 5) chk($sformatf("rst_all_c%0d", k), {pulse, busy, done}, '0);
        end
        reset = 1'b0;

        // simultaneous start+abort keeps the channel idle
        do_reset();
        set_ch(2, 0, 3, 0, 0, 1'b0);
        start[2] = 1'b1;
        abort[2] = 1'b1;
        tick();
        chk("start_abort_busy", busy[2], 1'b0);
        start[2] = 1'b0;
        abort[2] = 1'b0;
        tick();
        chk("start_abort_idle", {pulse[2], busy[2]}, 2'b00);

        // back-to-back: new start accepted in the done cycle
        do_reset();
        set_ch(0, 0, 2, 0, 0, 1'b0);
        for (int cyc = 0; cyc < 9; cyc++) begin
            start[0] = (cyc == 0 || cyc == 3);
            tick();
            k = cyc + 1;
            chk($sformatf("b2b_pulse_c%0d", k), pulse[0], k inside {1, 2, 4, 5});
            chk($sformatf("b2b_done_c%0d", k), done[0], k == 3 || k == 6);
        end

        // maximum width field gives exactly that many cycles
        do_reset();
        set_ch(1, 0, 65535, 0, 0, 1'b0);
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        cntp = 0;
        seen = 1'b0;
        for (int n = 0; n < 70000 && !seen; n++) begin
            if (pulse[1]) cntp++;
            if (done[1]) seen = 1'b1;
            else tick();
        end
        chk("maxw_done_seen", seen, 1'b1);
        chk("maxw_width", cntp, 65535);

        // random traffic on all channels against the model
        do_reset();
        for (int c = 0; c < N; c++) begin
            mq[c].delete();
            m_p[c] = 0; m_b[c] = 0; m_d[c] = 0; m_l[c] = 0; m_we[c] = 0;
        end
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < N; c++) begin
                set_ch(c, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 2), $urandom_range(0, 2),
                       1'($urandom_range(0, 1)));
                wait_on[c] = ($urandom_range(0, 2) == 0);
                start[c]   = ($urandom_range(0, 3) == 0);
                abort[c]   = ($urandom_range(0, 40) == 0);
            end
            reset = ($urandom_range(0, 300) == 0);
            model_step();
            tick();
            for (int c = 0; c < N; c++) begin
                ep[c] = m_p[c]; eb[c] = m_b[c]; ed[c] = m_d[c];
            end
            chk($sformatf("rnd%0d_pulse", n), pulse, ep);
            chk($sformatf("rnd%0d_busy", n), busy, eb);
            chk($sformatf("rnd%0d_done", n), done, ed);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
